// File: rtl/aes_round_key_scheduler.sv
// Controller for an 8-bit serial AES-128 key expansion datapath: loads the cipher
// key bytewise, sequences 10 expansion rounds, stores all 11 round keys for readout.
module aes_round_key_scheduler (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid_i,
    input  logic [7:0]   key_byte_i,
    output logic         key_ready_o,
    output logic         ke_en_o,
    output logic [7:0]   ke_key_byte_o,
    output logic         ke_select_input_o,
    output logic         ke_select_sbox_o,
    output logic         ke_select_last_out_o,
    output logic         ke_select_bit_out_o,
    output logic [7:0]   ke_rcon_en_o,
    output logic [3:0]   ke_round_o,
    input  logic [7:0]   ke_byte_i,
    output logic         keys_ready_o,
    input  logic         rk_req_i,
    input  logic [3:0]   rk_idx_i,
    output logic         rk_ack_o,
    output logic         rk_err_o,
    output logic [127:0] rk_data_o,
    output logic         busy_o
);

    // Key input: a byte transfers on a rising edge where key_valid_i && key_ready_o;
    // valid may be dropped at any time (bubble) and freezes loading until it returns.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ONE, S_TWO, S_THREE, S_NORM, S_SHIFT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     round_q, round_d;
    logic [119:0]   cap_q, cap_d;
    logic           keys_ready_q, keys_ready_d;
    logic           rk_ack_q, rk_ack_d;
    logic           rk_err_q, rk_err_d;
    logic [127:0]   rk_data_q, rk_data_d;

    logic [127:0]   rk_q [0:10];
    logic           rk0_shift;
    logic           rk_we;
    logic [127:0]   cap_word;

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        round_d              = round_q;
        cap_d                = cap_q;
        keys_ready_d         = keys_ready_q;
        rk_ack_d             = 1'b0;
        rk_err_d             = rk_err_q;
        rk_data_d            = rk_data_q;
        rk0_shift            = 1'b0;
        rk_we                = 1'b0;
        cap_word             = {cap_q, ke_byte_i};
        key_ready_o          = 1'b0;
        ke_en_o              = 1'b0;
        ke_select_input_o    = 1'b0;
        ke_select_sbox_o     = 1'b1;
        ke_select_last_out_o = 1'b0;
        ke_select_bit_out_o  = 1'b0;
        ke_rcon_en_o         = 8'h00;

        case (state_q)
            S_IDLE, S_DONE: begin
                key_ready_o = !rk_req_i;
                // Skip the cycle that carries the ack so a requester dropping req
                // right after the ack is served exactly once.
                if (state_q == S_DONE && rk_req_i && !rk_ack_q) begin
                    rk_ack_d = 1'b1;
                    if (rk_idx_i > 4'd10) begin
                        rk_err_d  = 1'b1;
                        rk_data_d = '0;
                    end else begin
                        rk_err_d  = 1'b0;
                        rk_data_d = rk_q[rk_idx_i];
                    end
                end
                if (key_valid_i && !rk_req_i) begin
                    state_d      = S_LOAD;
                    cnt_d        = 4'd1;
                    round_d      = 4'd0;
                    keys_ready_d = 1'b0;
                    rk0_shift    = 1'b1;
                end
            end
            S_LOAD: begin
                key_ready_o = 1'b1;
                ke_en_o     = key_valid_i;
                if (key_valid_i) begin
                    rk0_shift = 1'b1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_ONE;
                        cnt_d   = 4'd0;
                        round_d = 4'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_ONE: begin
                ke_en_o             = 1'b1;
                ke_select_input_o   = 1'b1;
                ke_select_bit_out_o = 1'b1;
                ke_rcon_en_o        = 8'hff;
                cap_d               = cap_word[119:0];
                state_d             = S_TWO;
            end
            S_TWO: begin
                ke_en_o             = 1'b1;
                ke_select_input_o   = 1'b1;
                ke_select_bit_out_o = 1'b1;
                cap_d               = cap_word[119:0];
                if (cnt_q == 4'd1) begin
                    state_d = S_THREE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_THREE: begin
                ke_en_o             = 1'b1;
                ke_select_input_o   = 1'b1;
                ke_select_sbox_o    = 1'b0;
                ke_select_bit_out_o = 1'b1;
                cap_d               = cap_word[119:0];
                state_d             = S_NORM;
            end
            S_NORM: begin
                ke_en_o              = 1'b1;
                ke_select_input_o    = 1'b1;
                ke_select_sbox_o     = 1'b0;
                ke_select_last_out_o = 1'b1;
                ke_select_bit_out_o  = 1'b1;
                cap_d                = cap_word[119:0];
                if (cnt_q == 4'd7) begin
                    state_d = S_SHIFT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SHIFT: begin
                ke_en_o              = 1'b1;
                ke_select_input_o    = 1'b1;
                ke_select_sbox_o     = 1'b0;
                ke_select_last_out_o = 1'b1;
                cap_d                = cap_word[119:0];
                if (cnt_q == 4'd3) begin
                    // The 16th byte of the round arrives this cycle, so store the
                    // shift register together with it.
                    rk_we = 1'b1;
                    cnt_d = 4'd0;
                    if (round_q == 4'd10) begin
                        state_d      = S_DONE;
                        keys_ready_d = 1'b1;
                    end else begin
                        state_d = S_ONE;
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            round_q      <= 4'd0;
            cap_q        <= '0;
            keys_ready_q <= 1'b0;
            rk_ack_q     <= 1'b0;
            rk_err_q     <= 1'b0;
            rk_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            round_q      <= round_d;
            cap_q        <= cap_d;
            keys_ready_q <= keys_ready_d;
            rk_ack_q     <= rk_ack_d;
            rk_err_q     <= rk_err_d;
            rk_data_q    <= rk_data_d;
        end
    end

    // Round-key storage keeps its contents across reset; keys_ready_o qualifies it.
    always_ff @(posedge clk) begin
        if (rk0_shift) rk_q[0] <= {rk_q[0][119:0], key_byte_i};
        if (rk_we) rk_q[round_q] <= cap_word;
    end

    assign ke_key_byte_o = key_byte_i;
    assign ke_round_o    = round_q;
    assign keys_ready_o  = keys_ready_q;
    assign rk_ack_o      = rk_ack_q;
    assign rk_err_o      = rk_err_q;
    assign rk_data_o     = rk_data_q;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_aes_round_key_scheduler.sv
// Bench for aes_round_key_scheduler: an AES-128 reference expansion drives a
// datapath stand-in and supplies expected round keys, timing and mux decodes.
module tb_aes_round_key_scheduler;

    logic         clk;
    logic         rst;
    logic         key_valid_i;
    logic [7:0]   key_byte_i;
    logic         key_ready_o;
    logic         ke_en_o;
    logic [7:0]   ke_key_byte_o;
    logic         ke_select_input_o;
    logic         ke_select_sbox_o;
    logic         ke_select_last_out_o;
    logic         ke_select_bit_out_o;
    logic [7:0]   ke_rcon_en_o;
    logic [3:0]   ke_round_o;
    logic [7:0]   ke_byte_i;
    logic         keys_ready_o;
    logic         rk_req_i;
    logic [3:0]   rk_idx_i;
    logic         rk_ack_o;
    logic         rk_err_o;
    logic [127:0] rk_data_o;
    logic         busy_o;

    aes_round_key_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .key_valid_i          (key_valid_i),
        .key_byte_i           (key_byte_i),
        .key_ready_o          (key_ready_o),
        .ke_en_o              (ke_en_o),
        .ke_key_byte_o        (ke_key_byte_o),
        .ke_select_input_o    (ke_select_input_o),
        .ke_select_sbox_o     (ke_select_sbox_o),
        .ke_select_last_out_o (ke_select_last_out_o),
        .ke_select_bit_out_o  (ke_select_bit_out_o),
        .ke_rcon_en_o         (ke_rcon_en_o),
        .ke_round_o           (ke_round_o),
        .ke_byte_i            (ke_byte_i),
        .keys_ready_o         (keys_ready_o),
        .rk_req_i             (rk_req_i),
        .rk_idx_i             (rk_idx_i),
        .rk_ack_o             (rk_ack_o),
        .rk_err_o             (rk_err_o),
        .rk_data_o            (rk_data_o),
        .busy_o               (busy_o)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] SPEC_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SPEC_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] SPEC_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [11:0] DEC_IDLE = 12'b0100_0000_0000;

    int n_tests = 0;
    int n_fail = 0;
    logic kr_model;
    logic [7:0] sbox [256];
    logic [127:0] model_rk [11];
    logic [128:0] exp_q [$];

    // Datapath stand-in: emits the reference round key MSB byte first, one byte
    // per enabled expansion cycle.
    logic [3:0]   pos;
    logic [127:0] stub_word;
    always @(posedge clk or posedge rst) begin
        if (rst) pos <= 4'd0;
        else if (ke_en_o && ke_select_input_o) pos <= pos + 4'd1;
    end
    assign stub_word = (ke_round_o >= 4'd1 && ke_round_o <= 4'd10) ? model_rk[ke_round_o] : '0;
    assign ke_byte_i = stub_word[{4'd15 - pos, 3'b000} +: 8];

    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [11:0] dec_now();
        return {ke_select_input_o, ke_select_sbox_o, ke_select_last_out_o, ke_select_bit_out_o, ke_rcon_en_o};
    endfunction

    // Expected selects by position inside a 16-cycle round.
    function automatic logic [11:0] exp_dec(input int p);
        if (p == 0) return {4'b1101, 8'hff};
        if (p <= 2) return {4'b1101, 8'h00};
        if (p == 3) return {4'b1001, 8'h00};
        if (p <= 11) return {4'b1011, 8'h00};
        return {4'b1010, 8'h00};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, 129'(key_ready_o), 129'(1));
        check({tag, "_ke_en"}, 129'(ke_en_o), 129'(0));
        check({tag, "_keys_ready"}, 129'(keys_ready_o), 129'(0));
        check({tag, "_ack"}, 129'(rk_ack_o), 129'(0));
        check({tag, "_err_data"}, {rk_err_o, rk_data_o}, 129'(0));
        check({tag, "_busy"}, 129'(busy_o), 129'(0));
        check({tag, "_round"}, 129'(ke_round_o), 129'(0));
        check({tag, "_dec"}, 129'(dec_now()), 129'(DEC_IDLE));
    endtask

    // Driver: stream a key (mode 0 back-to-back, 1 bubble before every byte after
    // the first, 2 random bubbles), then follow the 160 expansion cycles.
    task automatic load_key(input logic [127:0] key, input int mode, input bit hold_req, input int abort_at);
        expand_key(key);
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1))) begin
                @(negedge clk);
                key_valid_i = 1'b0;
                key_byte_i = 8'($urandom);
                #1;
                check("bubble_en", 129'(ke_en_o), 129'(0));
                check("bubble_ready", 129'(key_ready_o), 129'(1));
                check("bubble_busy", 129'(busy_o), 129'(1));
            end
            @(negedge clk);
            key_valid_i = 1'b1;
            key_byte_i = key[8*(15-i) +: 8];
            if (hold_req && i == 1) begin
                rk_req_i = 1'b1;
                rk_idx_i = 4'd0;
            end
            #1;
            check("load_ready", 129'(key_ready_o), 129'(1));
            check("load_en", 129'(ke_en_o), 129'(i != 0));
            check("load_fwd", 129'(ke_key_byte_o), 129'(key[8*(15-i) +: 8]));
            check("load_dec", 129'(dec_now()), 129'(DEC_IDLE));
            check("load_busy", 129'(busy_o), 129'(i != 0));
            check("load_keys_ready", 129'(keys_ready_o), 129'(i == 0 ? kr_model : 1'b0));
            check("load_ack", 129'(rk_ack_o), 129'(0));
        end
        kr_model = 1'b0;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            key_valid_i = 1'b0;
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst = 1'b0;
                #1;
                check_reset_outputs("abort_release");
                return;
            end
            #1;
            check("exp_en", 129'(ke_en_o), 129'(1));
            check("exp_dec", 129'(dec_now()), 129'(exp_dec(k % 16)));
            check("exp_round", 129'(ke_round_o), 129'(k / 16 + 1));
            check("exp_busy", 129'(busy_o), 129'(1));
            check("exp_keys_ready", 129'(keys_ready_o), 129'(0));
            check("exp_key_ready", 129'(key_ready_o), 129'(0));
            check("exp_ack", 129'(rk_ack_o), 129'(0));
        end
        @(negedge clk);
        #1;
        check("done_keys_ready", 129'(keys_ready_o), 129'(1));
        check("done_busy", 129'(busy_o), 129'(0));
        check("done_en", 129'(ke_en_o), 129'(0));
        check("done_dec", 129'(dec_now()), 129'(DEC_IDLE));
        check("done_ack", 129'(rk_ack_o), 129'(0));
        check("done_key_ready", 129'(key_ready_o), 129'(!rk_req_i));
        kr_model = 1'b1;
    endtask

    // Driver + scoreboard: issue one read, expect an ack exactly one cycle later.
    task automatic read_rk(input logic [3:0] idx, input logic [128:0] exp);
        int n;
        logic [128:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        rk_req_i = 1'b1;
        rk_idx_i = idx;
        #1;
        check("rd_key_ready", 129'(key_ready_o), 129'(0));
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!rk_ack_o && n < 8);
        rk_req_i = 1'b0;
        check("rd_latency", 129'(n), 129'(1));
        e = exp_q.pop_front();
        check("rd_data", {rk_err_o, rk_data_o}, e);
        @(negedge clk);
        #1;
        check("rd_ack_pulse", 129'(rk_ack_o), 129'(0));
        check("rd_hold", {rk_err_o, rk_data_o}, e);
    endtask

    function automatic logic [128:0] exp_read(input logic [3:0] idx);
        if (idx > 4'd10) return {1'b1, 128'h0};
        return {1'b0, model_rk[idx]};
    endfunction

    task automatic random_reads(input int count);
        logic [3:0] idx;
        for (int i = 0; i < count; i++) begin
            idx = 4'($urandom_range(0, 15));
            read_rk(idx, exp_read(idx));
        end
    endtask

    initial begin
        rst = 1'b0;
        key_valid_i = 1'b0;
        key_byte_i = 8'h00;
        rk_req_i = 1'b0;
        rk_idx_i = 4'd0;
        kr_model = 1'b0;
        #1 rst = 1'b1;
        build_sbox();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_release");
        @(negedge clk);
        #1;
        check_reset_outputs("idle");

        // Reference key, back-to-back bytes.
        load_key(SPEC_KEY, 0, 1'b0, -1);
        read_rk(4'd0, {1'b0, SPEC_KEY});
        read_rk(4'd1, {1'b0, SPEC_RK1});
        read_rk(4'd10, {1'b0, SPEC_RK10});
        read_rk(4'd12, {1'b1, 128'h0});
        read_rk(4'd5, exp_read(4'd5));

        // Same key with a bubble between bytes.
        load_key(SPEC_KEY, 1, 1'b0, -1);
        read_rk(4'd1, {1'b0, SPEC_RK1});
        read_rk(4'd10, {1'b0, SPEC_RK10});
        read_rk(4'd0, {1'b0, SPEC_KEY});

        // Reset in round 5 NORM, then reload a fresh key.
        load_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 4 * 16 + 6);
        load_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, -1);
        random_reads(8);

        // Request held from LOAD, then request colliding with a key byte in DONE.
        load_key({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, -1);
        @(negedge clk);
        #1;
        check("held_ack", 129'(rk_ack_o), 129'(1));
        check("held_data", {rk_err_o, rk_data_o}, exp_read(4'd0));
        rk_req_i = 1'b0;
        @(negedge clk);
        rk_req_i = 1'b1;
        rk_idx_i = 4'd10;
        key_valid_i = 1'b1;
        key_byte_i = 8'($urandom);
        #1;
        check("collide_key_ready", 129'(key_ready_o), 129'(0));
        @(negedge clk);
        #1;
        check("collide_ack", 129'(rk_ack_o), 129'(1));
        check("collide_data", {rk_err_o, rk_data_o}, exp_read(4'd10));
        check("collide_busy", 129'(busy_o), 129'(0));
        check("collide_keys_ready", 129'(keys_ready_o), 129'(1));
        rk_req_i = 1'b0;
        key_valid_i = 1'b0;
        @(negedge clk);
        #1;
        check("collide_ack_pulse", 129'(rk_ack_o), 129'(0));

        // Further random keys and reads.
        for (int t = 0; t < 3; t++) begin
            load_key({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), 1'b0, -1);
            random_reads(5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
